instr_fetch_unit: RTL and testbench

Instruction fetch stage that drives the 32-bit `inst` word consumed by the main control unit `mcu`. Holds the program counter and a small instruction memory with a write port for bench/boot loading. Registers each fetched word into an IF/ID output register. Supports pipeline stall and branch redirect with a one-bubble flush.

---
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control inputs, instruction-memory write port and the IF/ID outputs.
// master = pipeline control / loader side, slave = instr_fetch_unit.
interface instr_fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        fetch_fault;

    modport master (
        output stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
        input  inst, pc_out, inst_valid, fetch_fault
    );

    modport slave (
        input  stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
        output inst, pc_out, inst_valid, fetch_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, small instruction memory and registered IF/ID output.
// Optional macro IFETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky fetch_fault.
module instr_fetch_unit #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.slave bus
);
    localparam int unsigned AW       = $clog2(IMEM_DEPTH);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [1:0]  S_BOOT   = 2'd0;
    localparam logic [1:0]  S_RUN    = 2'd1;
    localparam logic [1:0]  S_BUBBLE = 2'd2;

    logic [31:0] mem [IMEM_DEPTH];

    logic [1:0]  state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] inst_q, inst_n;
    logic [31:0] pc_out_q, pc_out_n;
    logic        valid_q, valid_n;
    logic        fault_q, fault_n;

    logic [31:0] fetch_word_c;
    logic [31:0] target_c;
    logic        misalign_c;

    // Instruction memory: synchronous write, asynchronous read, not cleared by reset
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_waddr[AW+1:2]] <= bus.imem_wdata;
        end
    end

    assign fetch_word_c = mem[pc[AW+1:2]];

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign target_c   = bus.branch_target;
    assign misalign_c = |bus.branch_target[1:0];
`else
    assign target_c   = {bus.branch_target[31:2], 2'b00};
    assign misalign_c = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        inst_n   = inst_q;
        pc_out_n = pc_out_q;
        valid_n  = valid_q;
        fault_n  = fault_q;

        case (state)
            S_BOOT: begin
                if (!bus.stall) begin
                    inst_n   = fetch_word_c;
                    pc_out_n = pc;
                    valid_n  = 1'b1;
                    pc_n     = pc + 32'd4;
                    state_n  = S_RUN;
                end
            end
            S_RUN, S_BUBBLE: begin
                if (fault_q) begin
                    // Parked after a misaligned redirect until reset
                    valid_n = 1'b0;
                end else if (bus.branch_taken) begin
                    inst_n  = NOP;
                    valid_n = 1'b0;
                    state_n = S_BUBBLE;
                    if (misalign_c) begin
                        fault_n = 1'b1;
                    end else begin
                        pc_n = target_c;
                    end
                end else if (!bus.stall) begin
                    inst_n   = fetch_word_c;
                    pc_out_n = pc;
                    valid_n  = 1'b1;
                    pc_n     = pc + 32'd4;
                    state_n  = S_RUN;
                end
            end
            default: begin
                state_n = S_BOOT;
            end
        endcase
    end

    // State and IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            inst_q   <= NOP;
            pc_out_q <= 32'h0000_0000;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            inst_q   <= inst_n;
            pc_out_q <= pc_out_n;
            valid_q  <= valid_n;
            fault_q  <= fault_n;
        end
    end

    assign bus.inst       = inst_q;
    assign bus.pc_out     = pc_out_q;
    assign bus.inst_valid = valid_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.imem_waddr[31:AW+2], bus.imem_waddr[1:0],
                           bus.branch_target[1:0], fault_n};
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed test-plan sequence followed by random traffic.
module tb_instr_fetch_unit;
    localparam int          DEPTH = 64;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_out;
        logic        valid;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    instr_fetch_if bus ();

    instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        expq [$];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference model: a word memory, a PC and two flags
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    exp_t        m_out;
    bit          m_started;
    bit          m_faulted;

    task automatic model_fetch();
        m_out.inst   = m_mem[(m_pc >> 2) % DEPTH];
        m_out.pc_out = m_pc;
        m_out.valid  = 1'b1;
        m_pc         = m_pc + 32'd4;
    endtask

    task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t,
                              input logic we, input logic [31:0] wa, input logic [31:0] wd);
        if (r) begin
            m_pc      = RPC;
            m_out     = '{inst: NOP, pc_out: 32'h0, valid: 1'b0, fault: 1'b0};
            m_started = 1'b0;
            m_faulted = 1'b0;
        end else if (!m_started) begin
            if (!s) begin
                model_fetch();
                m_started = 1'b1;
            end
        end else if (m_faulted) begin
            m_out.valid = 1'b0;
        end else if (b) begin
            m_out.inst  = NOP;
            m_out.valid = 1'b0;
            if (TRAP && t[1:0] != 2'b00) begin
                m_faulted   = 1'b1;
                m_out.fault = 1'b1;
            end else begin
                m_pc = t & ~32'd3;
            end
        end else if (!s) begin
            model_fetch();
        end
        // Write lands after the fetch read so a same-word fetch sees the old value
        if (we) m_mem[(wa >> 2) % DEPTH] = wd;
    endtask

    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic we = 1'b0, input logic [31:0] wa = 32'h0,
                       input logic [31:0] wd = 32'h0);
        @(negedge clk);
        reset             = r;
        bus.stall         = s;
        bus.branch_taken  = b;
        bus.branch_target = t;
        bus.imem_we       = we;
        bus.imem_waddr    = wa;
        bus.imem_wdata    = wd;
        model_step(r, s, b, t, we, wa, wd);
        expq.push_back(m_out);
    endtask

    // Monitor: one expected entry per active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                exp_t e;
                exp_t a;
                e = expq.pop_front();
                a = '{inst: bus.inst, pc_out: bus.pc_out, valid: bus.inst_valid,
                      fault: bus.fetch_fault};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d: got inst=%h pc_out=%h valid=%b fault=%b, want inst=%h pc_out=%h valid=%b fault=%b",
                             vectors, a.inst, a.pc_out, a.valid, a.fault,
                             e.inst, e.pc_out, e.valid, e.fault);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;

        // Fill memory under reset, then the test-plan program at words 0..3
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0, 1, 32'(i * 4), $urandom);
        cyc(1, 0, 0, 0, 1, 32'h0, 32'h0000_0063);
        cyc(1, 0, 0, 0, 1, 32'h4, 32'h0000_0023);
        cyc(1, 0, 0, 0, 1, 32'h8, 32'h0000_0033);
        cyc(1, 0, 0, 0, 1, 32'hC, 32'h0000_0003);

        // Sequential fetch with a 3-cycle stall on pc 4
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // Redirect to 0, then branch plus stall
        cyc(0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 32'h0);
        cyc(0, 0, 0, 0);
        // Redirect again while in the bubble, stall in the bubble
        cyc(0, 0, 1, 32'h8);
        cyc(0, 0, 1, 32'hC);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // Memory wrap-around
        cyc(0, 0, 1, 32'h0000_00FC);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // Same-edge write and fetch of word 1 (pc 0x104): old word captured
        cyc(0, 0, 0, 0, 1, 32'h0000_0104, 32'hCAFE_0001);
        cyc(0, 0, 1, 32'h4);
        cyc(0, 0, 0, 0);
        // 32-bit PC wrap
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // Misaligned redirect
        cyc(0, 0, 1, 32'h0000_0006);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h0000_0010);
        cyc(0, 0, 0, 0);
        // Reset mid-stall with other inputs active
        cyc(1, 1, 1, 32'h20);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt = tgt & 32'h0000_01FC;
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            cyc(logic'($urandom_range(0, 49) == 0),
                logic'($urandom_range(0, 3) == 0),
                logic'($urandom_range(0, 6) == 0),
                tgt,
                logic'($urandom_range(0, 4) == 0),
                $urandom & 32'h0000_03FF,
                $urandom);
        end

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
